// File: rtl/scarf_uart_cmd_if.sv
// rtl/scarf_uart_cmd_if.sv - UART/SCARF framing bus between command block and its environment
interface scarf_uart_cmd_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [7:0] data_in;
  logic       data_in_valid;
  logic       data_in_finished;
  logic [6:0] slave_id;
  logic       rnw;
  logic [7:0] read_data_in;
  logic [7:0] tx_data;
  logic       tx_send;
  logic       tx_busy;
  logic       resp_overflow;

  // master: the command framer itself
  modport master (
    input  rx_data, rx_valid, read_data_in, tx_busy,
    output data_in, data_in_valid, data_in_finished, slave_id, rnw,
           tx_data, tx_send, resp_overflow
  );

  // slave: UART receiver/transmitter and slave blocks around the framer
  modport slave (
    output rx_data, rx_valid, read_data_in, tx_busy,
    input  data_in, data_in_valid, data_in_finished, slave_id, rnw,
           tx_data, tx_send, resp_overflow
  );
endinterface

// File: rtl/scarf_uart_cmd.sv
// rtl/scarf_uart_cmd.sv - frames UART rx bytes into SCARF transactions, queues read data to tx
module scarf_uart_cmd #(
  parameter logic [15:0] IDLE_TIMEOUT = 16'd2000,
  parameter int          RD_LATENCY   = 3,
  parameter int          FIFO_DEPTH   = 4
) (
  input  logic              clk,
  input  logic              rst_n_sync,
  scarf_uart_cmd_if.master  bus
);

  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, DATA, FINISH} state_t;

  state_t              state, state_nxt;
  logic                hdr_take, byte_take;
  logic [15:0]         tmo_cnt;
  logic [7:0]          data_in_r;
  logic                data_in_valid_r;
  logic [6:0]          slave_id_r;
  logic                rnw_r;
  logic [RD_LATENCY-1:0] rd_pipe;
  logic [7:0]          mem [FIFO_DEPTH];
  logic [AW:0]         wr_ptr, rd_ptr;
  logic                fifo_empty, fifo_full, push, pop, do_push;
  logic [7:0]          tx_data_r;
  logic                tx_send_r;
  logic                ovf_r;

  // Next-state decode: header opens a frame, payload reloads timeout, expiry closes it
  always_comb begin
    state_nxt = state;
    hdr_take  = 1'b0;
    byte_take = 1'b0;
    case (state)
      IDLE: begin
        if (bus.rx_valid) begin
          hdr_take  = 1'b1;
          state_nxt = DATA;
        end
      end
      DATA: begin
        // A byte arriving on the expiry cycle keeps the frame open
        if (bus.rx_valid) begin
          byte_take = 1'b1;
        end else if (tmo_cnt == 16'd0) begin
          state_nxt = FINISH;
        end
      end
      FINISH:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n_sync) begin
    if (!rst_n_sync) state <= IDLE;
    else             state <= state_nxt;
  end

  // Frame registers: header fields, forwarded payload and idle timeout
  always_ff @(posedge clk or negedge rst_n_sync) begin
    if (!rst_n_sync) begin
      data_in_r       <= 8'd0;
      data_in_valid_r <= 1'b0;
      slave_id_r      <= 7'd0;
      rnw_r           <= 1'b0;
      tmo_cnt         <= 16'd0;
    end else begin
      data_in_valid_r <= byte_take;
      if (byte_take) data_in_r <= bus.rx_data;
      if (hdr_take) begin
        slave_id_r <= bus.rx_data[6:0];
        rnw_r      <= bus.rx_data[7];
      end else if (state == FINISH) begin
        slave_id_r <= 7'd0;
        rnw_r      <= 1'b0;
      end
      if (hdr_take || byte_take)               tmo_cnt <= IDLE_TIMEOUT;
      else if (state == DATA && tmo_cnt != 0)  tmo_cnt <= tmo_cnt - 16'd1;
    end
  end

  // Read-latency token pipe; tokens already launched survive the end of the frame
  always_ff @(posedge clk or negedge rst_n_sync) begin
    if (!rst_n_sync) rd_pipe <= '0;
    else             rd_pipe <= {rd_pipe[RD_LATENCY-2:0], data_in_valid_r & rnw_r};
  end

  assign push       = rd_pipe[RD_LATENCY-1];
  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop        = !fifo_empty && !bus.tx_busy && !tx_send_r;
  // When full, a simultaneous pop frees the slot being written
  assign do_push    = push && (!fifo_full || pop);

  // Response FIFO storage
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= bus.read_data_in;
  end

  // FIFO pointers, transmit handshake and sticky overflow flag
  always_ff @(posedge clk or negedge rst_n_sync) begin
    if (!rst_n_sync) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      tx_data_r <= 8'd0;
      tx_send_r <= 1'b0;
      ovf_r     <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) begin
        rd_ptr    <= rd_ptr + 1'b1;
        tx_data_r <= mem[rd_ptr[AW-1:0]];
      end
      tx_send_r <= pop;
      if (hdr_take)                      ovf_r <= 1'b0;
      else if (push && fifo_full && !pop) ovf_r <= 1'b1;
    end
  end

  assign bus.data_in          = data_in_r;
  assign bus.data_in_valid    = data_in_valid_r;
  assign bus.data_in_finished = (state == FINISH);
  assign bus.slave_id         = slave_id_r;
  assign bus.rnw              = rnw_r;
  assign bus.tx_data          = tx_data_r;
  assign bus.tx_send          = tx_send_r;
  assign bus.resp_overflow    = ovf_r;

endmodule
